// File: rtl/occ_arbiter_pkg.sv
// Shared definitions for the Occ ROM arbiter: base codes, the index -1
// address and the per-base count extraction from a packed Occ word.
package occ_arbiter_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } occ_base_e;

  localparam int unsigned OCC_ADDR_W = 8;
  localparam logic [OCC_ADDR_W-1:0] OCC_NEG1 = '1;

  // Widest per-base count the extraction helper supports.
  localparam int unsigned OCC_MAX_CNT_W = 16;

  function automatic logic [OCC_MAX_CNT_W-1:0] occ_base_count(
    input logic [4*OCC_MAX_CNT_W-1:0] word,
    input occ_base_e                  base,
    input int unsigned                cnt_w
  );
    logic [4*OCC_MAX_CNT_W-1:0] shifted;
    logic [OCC_MAX_CNT_W-1:0]   mask;
    shifted = word >> (32'(base) * cnt_w);
    mask    = {OCC_MAX_CNT_W{1'b1}} >> (OCC_MAX_CNT_W - cnt_w);
    return shifted[OCC_MAX_CNT_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/occ_arbiter_if.sv
// Bundle between the search-step requesters, the arbiter and the Occ ROM.
// slave = arbiter side, master = requesters plus ROM side.
interface occ_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned CNT_W   = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*2-1:0]      req_base;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [CNT_W-1:0]          resp_count;
  logic [4*CNT_W-1:0]        resp_word;
  logic                      rom_ce;
  logic [ADDR_W-1:0]         rom_addr;
  logic [4*CNT_W-1:0]        rom_data;
  logic                      rom_valid;
  logic                      err;

  modport slave (
    input  req_valid, req_addr, req_base, rom_data, rom_valid,
    output req_ready, resp_valid, resp_count, resp_word, rom_ce, rom_addr, err
  );

  modport master (
    output req_valid, req_addr, req_base, rom_data, rom_valid,
    input  req_ready, resp_valid, resp_count, resp_word, rom_ce, rom_addr, err
  );
endinterface

// File: rtl/occ_rr_grant.sv
// One-hot grant picker: first requester at or after rr_ptr_i (mod NUM_REQ).
// Tying rr_ptr_i to 0 gives plain lowest-index-wins priority.
module occ_rr_grant #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] gnt_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   pick;

  // Rotate so rr_ptr sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req_i, req_i} >> rr_ptr_i;
    req_rot = req_dbl[NUM_REQ-1:0];
    pick    = req_rot & (~req_rot + NUM_REQ'(1));
    gnt_dbl = {pick, pick} << rr_ptr_i;
    gnt_o   = gnt_dbl[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/occ_arbiter.sv
// Shares one Occ ROM port between NUM_REQ requesters: grant, issue, capture.
// Define OCC_ARB_RR_EN for round-robin grant; otherwise lowest index wins.
module occ_arbiter
  import occ_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned ADDR_W  = 8,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rst,
  occ_arbiter_if.slave      bus
);

  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] gnt;
  logic               grant_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [1:0]         sel_base;
  logic [PTR_W-1:0]   rr_ptr;

  logic               rom_ce_q,   rom_ce_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  occ_base_e          b_base_q,   b_base_d;
  logic [PTR_W-1:0]   b_id_q,     b_id_d;

  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [4*CNT_W-1:0] resp_word_q,  resp_word_d;
  logic [CNT_W-1:0]   resp_count_q, resp_count_d;
  logic               err_q,        err_d;

  logic [NUM_REQ-1:0]         id_onehot;
  logic [4*OCC_MAX_CNT_W-1:0] word_ext;

  // Stage A: no grant may leave while reset is held.
  assign req_masked = bus.req_valid & {NUM_REQ{~rst}};

  occ_rr_grant #(.NUM_REQ(NUM_REQ)) u_grant (
    .req_i    (req_masked),
    .rr_ptr_i (rr_ptr),
    .gnt_o    (gnt)
  );

  assign bus.req_ready = gnt;
  assign grant_any     = |gnt;

  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_base = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PTR_W'(i);
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_base = bus.req_base[2*i +: 2];
      end
    end
  end

`ifdef OCC_ARB_RR_EN
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  // Stage B: the address is held between lookups.
  always_comb begin
    rom_ce_d   = grant_any;
    rom_addr_d = rom_addr_q;
    b_base_d   = b_base_q;
    b_id_d     = b_id_q;
    if (grant_any) begin
      rom_addr_d = sel_addr;
      b_base_d   = occ_base_e'(sel_base);
      b_id_d     = gnt_idx;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign id_onehot[gi] = (b_id_q == PTR_W'(gi));
  end

  // Stage C: a missing rom_valid drops the lookup and latches err.
  always_comb begin
    resp_valid_d = '0;
    resp_word_d  = resp_word_q;
    resp_count_d = resp_count_q;
    err_d        = err_q;
    word_ext     = '0;
    word_ext[4*CNT_W-1:0] = bus.rom_data;
    if (rom_ce_q) begin
      if (bus.rom_valid) begin
        resp_valid_d = id_onehot;
        resp_word_d  = bus.rom_data;
        resp_count_d = CNT_W'(occ_base_count(word_ext, b_base_q, CNT_W));
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_ce_q     <= 1'b0;
      rom_addr_q   <= '0;
      b_base_q     <= BASE_A;
      b_id_q       <= '0;
      resp_valid_q <= '0;
      resp_word_q  <= '0;
      resp_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      rom_ce_q     <= rom_ce_d;
      rom_addr_q   <= rom_addr_d;
      b_base_q     <= b_base_d;
      b_id_q       <= b_id_d;
      resp_valid_q <= resp_valid_d;
      resp_word_q  <= resp_word_d;
      resp_count_q <= resp_count_d;
      err_q        <= err_d;
    end
  end

  assign bus.rom_ce     = rom_ce_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_word  = resp_word_q;
  assign bus.resp_count = resp_count_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_occ_arbiter.sv
// Scoreboard bench for occ_arbiter: grants are predicted at each negedge,
// expected responses queued with their due cycle and compared on arrival.
module tb_occ_arbiter;
  import occ_arbiter_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned CNT_W   = 8;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] addr;
    logic [1:0] base;
    bit         dropped;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rom_fault = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  sb_t               sb_q[$];
  sb_t               ent;
  int                m_ptr = 0;
  logic [7:0]        m_addr = '0;
  logic [31:0]       m_word = '0;
  logic [7:0]        m_count = '0;
  logic              m_err = 1'b0;
  logic [NUM_REQ-1:0] mon_rv;
  logic [NUM_REQ-1:0] mon_gnt;
  logic [NUM_REQ-1:0] last_gnt = '0;
  int                iss;
  int                gidx;

  occ_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

  occ_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    if (a == OCC_NEG1) return 32'h0;
    if (a == 8'h10)    return 32'h04030201;
    return {a ^ 8'hA5, a + 8'd7, a ^ 8'h3C, a + 8'd1};
  endfunction

  function automatic logic [7:0] exp_count(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign bus.rom_data  = rom_word(bus.rom_addr);
  assign bus.rom_valid = ~rom_fault;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    // capture stage
    mon_rv = '0;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      ent = sb_q.pop_front();
      if (!ent.dropped) begin
        mon_rv[ent.id] = 1'b1;
        m_word  = rom_word(ent.addr);
        m_count = exp_count(m_word, ent.base);
      end
      $display("resp id=%0d addr=%02h base=%0d dropped=%0d count=%02h word=%08h",
               ent.id, ent.addr, ent.base, ent.dropped, bus.resp_count, bus.resp_word);
    end
    check_eq("resp_valid", 64'(bus.resp_valid), 64'(mon_rv));
    check_eq("resp_word",  64'(bus.resp_word),  64'(m_word));
    check_eq("resp_count", 64'(bus.resp_count), 64'(m_count));
    check_eq("err",        64'(bus.err),        64'(m_err));

    // issue stage
    iss = -1;
    foreach (sb_q[k]) if (sb_q[k].due == cyc + 1) iss = k;
    if (iss >= 0) begin
      check_eq("rom_ce",   64'(bus.rom_ce),   64'd1);
      check_eq("rom_addr", 64'(bus.rom_addr), 64'(sb_q[iss].addr));
      if (rom_fault) begin
        sb_q[iss].dropped = 1'b1;
        m_err = 1'b1;
      end
    end else begin
      check_eq("rom_ce",   64'(bus.rom_ce),   64'd0);
      check_eq("rom_addr", 64'(bus.rom_addr), 64'(m_addr));
    end

    // grant stage
    mon_gnt = '0;
    gidx = -1;
    if (!rst) begin
      for (int o = 0; o < NUM_REQ; o++) begin
        if (gidx < 0 && bus.req_valid[(m_ptr + o) % NUM_REQ]) gidx = (m_ptr + o) % NUM_REQ;
      end
    end
    if (gidx >= 0) mon_gnt[gidx] = 1'b1;
    check_eq("req_ready", 64'(bus.req_ready), 64'(mon_gnt));
    if (gidx >= 0) begin
      ent.due     = cyc + 2;
      ent.id      = gidx;
      ent.addr    = bus.req_addr[gidx*ADDR_W +: ADDR_W];
      ent.base    = bus.req_base[2*gidx +: 2];
      ent.dropped = 1'b0;
      sb_q.push_back(ent);
      m_addr = ent.addr;
`ifdef OCC_ARB_RR_EN
      m_ptr = (gidx + 1) % NUM_REQ;
`endif
      $display("grant id=%0d addr=%02h base=%0d cyc=%0d", ent.id, ent.addr, ent.base, cyc);
    end
    last_gnt = mon_gnt;

    if (rst) begin
      sb_q.delete();
      m_ptr   = 0;
      m_addr  = '0;
      m_word  = '0;
      m_count = '0;
      m_err   = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] a0, input logic [1:0] b0,
                       input logic [7:0] a1, input logic [1:0] b1);
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_base  = {b1, b0};
  endtask

  logic [7:0] ra[2];
  logic [1:0] rb[2];
  logic [1:0] rv;

  initial begin
    drive(2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // single lookup
    drive(2'b01, 8'h10, BASE_C, 8'h00, 2'd0);
    tick();
    drive(2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    repeat (3) tick();

    // index -1
    drive(2'b10, 8'h00, 2'd0, OCC_NEG1, BASE_T);
    tick();
    drive(2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    repeat (3) tick();

    // contention, then requester 0 drops
    drive(2'b11, 8'h20, BASE_G, 8'h31, BASE_A);
    repeat (4) tick();
    drive(2'b10, 8'h00, 2'd0, 8'h31, BASE_A);
    repeat (2) tick();
    drive(2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    repeat (3) tick();

    // back-to-back
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 8'(8'h40 + i), 2'(i + 1), 8'h00, 2'd0);
      tick();
    end
    drive(2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    repeat (3) tick();

    // ROM fault during issue, then a normal lookup
    drive(2'b01, 8'h50, BASE_G, 8'h00, 2'd0);
    tick();
    drive(2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    rom_fault = 1'b1;
    tick();
    rom_fault = 1'b0;
    repeat (2) tick();
    drive(2'b01, 8'h51, BASE_T, 8'h00, 2'd0);
    tick();
    drive(2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    repeat (3) tick();

    // reset the cycle after a grant
    drive(2'b10, 8'h00, 2'd0, 8'h60, BASE_C);
    tick();
    drive(2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // random traffic; a requester changes its request only after transfer
    rv = '0;
    ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
    repeat (24) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] || last_gnt[i]) begin
          rv[i] = 1'($urandom_range(0, 1));
          ra[i] = 8'($urandom_range(0, 255));
          rb[i] = 2'($urandom_range(0, 3));
        end
      end
      drive(rv, ra[0], rb[0], ra[1], rb[1]);
      tick();
    end
    drive(2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    repeat (4) tick();

    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
